// File: rtl/uart_word_tx_if.sv
// Word-transmit handshake between the debug send FSM and the UART word transmitter.
interface uart_word_tx_if;
    logic        tx_start;
    logic [31:0] tx_data;
    logic        tx;
    logic        busy;
    logic        tx_dataready;

    // Debug send FSM side: issues words and watches for completion.
    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  busy,
        input  tx_dataready
    );

    // Transmitter side.
    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output busy,
        output tx_dataready
    );
endinterface

// File: rtl/uart_word_tx.sv
// Serialises one 32-bit word as four 8N1 UART frames, least significant byte first.
module uart_word_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_word_tx_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [1:0]       byte_idx, byte_idx_nxt;
    logic [31:0]      word_reg, word_reg_nxt;
    logic [7:0]       shift_reg, shift_reg_nxt;
    logic             tx_nxt;
    logic             busy_nxt;
    logic             dataready_nxt;
    logic             bit_done_c;

    assign bit_done_c = (baud_cnt == BIT_LAST);

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            word_reg  <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            byte_idx  <= byte_idx_nxt;
            word_reg  <= word_reg_nxt;
            shift_reg <= shift_reg_nxt;
        end
    end

    // Outputs are registered views of the next state, so tx never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.tx           <= 1'b1;
            bus.busy         <= 1'b0;
            bus.tx_dataready <= 1'b0;
        end else begin
            bus.tx           <= tx_nxt;
            bus.busy         <= busy_nxt;
            bus.tx_dataready <= dataready_nxt;
        end
    end

    // Next-state, baud timing and line value.
    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt;
        bit_idx_nxt   = bit_idx;
        byte_idx_nxt  = byte_idx;
        word_reg_nxt  = word_reg;
        shift_reg_nxt = shift_reg;
        tx_nxt        = 1'b1;
        busy_nxt      = 1'b0;
        dataready_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (bus.tx_start) begin
                    word_reg_nxt = bus.tx_data;
                    byte_idx_nxt = 2'd0;
                    baud_cnt_nxt = '0;
                    state_nxt    = START;
                end
            end
            START: begin
                if (bit_done_c) begin
                    baud_cnt_nxt  = '0;
                    shift_reg_nxt = word_reg[{byte_idx, 3'b000} +: 8];
                    bit_idx_nxt   = 3'd0;
                    state_nxt     = DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done_c) begin
                    baud_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt   = bit_idx + 3'd1;
                        shift_reg_nxt = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done_c) begin
                    baud_cnt_nxt = '0;
                    if (byte_idx == 2'd3) begin
                        state_nxt = DONE;
                    end else begin
                        byte_idx_nxt = byte_idx + 2'd1;
                        state_nxt    = START;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == START) begin
            tx_nxt = 1'b0;
        end else if (state_nxt == DATA) begin
            tx_nxt = shift_reg_nxt[0];
        end
        busy_nxt      = (state_nxt != IDLE);
        dataready_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: two instances (4 and 2 clocks per bit) against a line-time model.
module tb_uart_word_tx;

    logic clk;
    logic rst;

    logic        st_drv [2];
    logic [31:0] dt_drv [2];
    logic        txo    [2];
    logic        bz     [2];
    logic        drd    [2];

    uart_word_tx_if bus4 ();
    uart_word_tx_if bus2 ();

    assign bus4.tx_start = st_drv[0];
    assign bus4.tx_data  = dt_drv[0];
    assign bus2.tx_start = st_drv[1];
    assign bus2.tx_data  = dt_drv[1];
    assign txo[0] = bus4.tx;
    assign bz[0]  = bus4.busy;
    assign drd[0] = bus4.tx_dataready;
    assign txo[1] = bus2.tx;
    assign bz[1]  = bus2.busy;
    assign drd[1] = bus2.tx_dataready;

    uart_word_tx #(.CLKS_PER_BIT(4), .CNT_W(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    uart_word_tx #(.CLKS_PER_BIT(2), .CNT_W(16)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: t = cycles since the accepting edge (0 = idle), w = word in flight.
    int          cpb [2] = '{4, 2};
    int          t   [2] = '{0, 0};
    logic [31:0] w   [2] = '{32'h0, 32'h0};
    int          dr_cnt [2] = '{0, 0};

    // Line decoder on the 4-clock instance.
    logic [7:0] dec_q [$];
    int         ferr     = 0;
    bit         in_frame = 1'b0;
    int         cyc      = 0;
    logic [7:0] acc      = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_tx(input int i);
        int p, f, k;
        if (t[i] == 0 || t[i] > 40 * cpb[i]) return 1'b1;
        p = (t[i] - 1) / cpb[i];
        f = p / 10;
        k = p % 10;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return w[i][8 * f + k - 1];
    endfunction

    // Advance the model at each edge from the inputs seen at that edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                t[i] = 0;
            end else if (t[i] == 0) begin
                if (st_drv[i]) begin
                    t[i] = 1;
                    w[i] = dt_drv[i];
                end
            end else if (t[i] == 40 * cpb[i] + 1) begin
                t[i] = 0;
            end else begin
                t[i]++;
            end
        end
    end

    // Compare every cycle, count dataready pulses, decode the 4-clock line.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("tx%0d", i), 32'(txo[i]), 32'(exp_tx(i)));
            chk($sformatf("busy%0d", i), 32'(bz[i]), 32'(t[i] != 0));
            chk($sformatf("dr%0d", i), 32'(drd[i]), 32'(t[i] == 40 * cpb[i] + 1));
            if (drd[i]) dr_cnt[i]++;
        end
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && txo[0] == 1'b0) begin
                in_frame = 1'b1;
                cyc = 0;
            end else if (in_frame) begin
                cyc++;
            end
            if (in_frame && (cyc % 4) == 2) begin
                if (cyc / 4 == 0) begin
                    if (txo[0] !== 1'b0) ferr++;
                end else if (cyc / 4 <= 8) begin
                    acc[cyc / 4 - 1] = txo[0];
                end else begin
                    if (txo[0] !== 1'b1) ferr++;
                    dec_q.push_back(acc);
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic check_bytes(input string name, input int base, input logic [7:0] exp [$]);
        chk({name, "_count"}, 32'(dec_q.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size() && base + i < dec_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(dec_q[base + i]), 32'(exp[i]));
    endtask

    initial begin
        int n, low, qb, drb, fb;
        logic [7:0] exp_b [$];

        st_drv[0] = 1'b0; st_drv[1] = 1'b0;
        dt_drv[0] = '0;   dt_drv[1] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset / idle.
        @(posedge clk); #2;
        chk("rst_tx", 32'(txo[0]), 32'd1);
        chk("rst_busy", 32'(bz[0]), 32'd0);
        chk("rst_dr", 32'(drd[0]), 32'd0);
        repeat (100) @(negedge clk);
        chk("idle_dr_cnt", 32'(dr_cnt[0]), 32'd0);

        // Single word, data change after accept, ignored requests in DATA and DONE.
        qb = dec_q.size(); fb = ferr;
        @(negedge clk);
        dt_drv[0] = 32'h12345678; st_drv[0] = 1'b1;
        chk("pre_start_tx", 32'(txo[0]), 32'd1);
        @(posedge clk); #2;
        st_drv[0] = 1'b0; dt_drv[0] = 32'hFFFF_FFFF;
        chk("start_bit", 32'(txo[0]), 32'd0);
        n = 1;
        while (!drd[0] && n < 400) begin
            @(posedge clk); #2;
            n++;
            if (n == 20) st_drv[0] = 1'b1;
            if (n == 21) st_drv[0] = 1'b0;
        end
        chk("dr_latency", 32'(n), 32'd161);
        st_drv[0] = 1'b1;
        @(posedge clk); #2;
        st_drv[0] = 1'b0;
        chk("dr_width", 32'(drd[0]), 32'd0);
        chk("idle_after_done", 32'(bz[0]), 32'd0);
        repeat (200) @(posedge clk); #2;
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
        check_bytes("single", qb, exp_b);
        chk("single_ferr", 32'(ferr - fb), 32'd0);
        chk("single_dr_cnt", 32'(dr_cnt[0]), 32'd1);

        // Back-to-back with tx_start held.
        qb = dec_q.size(); drb = dr_cnt[0];
        @(negedge clk);
        dt_drv[0] = 32'hA5A5A5A5; st_drv[0] = 1'b1;
        @(posedge clk); #2;
        dt_drv[0] = 32'h0000_0000;
        n = 0;
        while (bz[0] && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        chk("b2b_first_len", 32'(n), 32'd161);
        chk("b2b_gap_tx", 32'(txo[0]), 32'd1);
        @(posedge clk); #2;
        chk("b2b_restart", 32'(txo[0]), 32'd0);
        st_drv[0] = 1'b0;
        n = 0;
        while (!drd[0] && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        repeat (50) @(posedge clk); #2;
        exp_b = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes("b2b", qb, exp_b);
        chk("b2b_dr_cnt", 32'(dr_cnt[0] - drb), 32'd2);

        // Reset during byte 2, data bit 3 (a zero bit of 0xF7).
        drb = dr_cnt[0];
        @(negedge clk);
        dt_drv[0] = 32'h55F73C0F; st_drv[0] = 1'b1;
        @(posedge clk); #2;
        st_drv[0] = 1'b0;
        repeat (97) @(posedge clk); #2;
        chk("pre_rst_bit", 32'(txo[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_tx", 32'(txo[0]), 32'd1);
        chk("rst_mid_busy", 32'(bz[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_dr", 32'(dr_cnt[0] - drb), 32'd0);
        qb = dec_q.size(); fb = ferr;
        dt_drv[0] = 32'h0BADF00D; st_drv[0] = 1'b1;
        @(posedge clk); #2;
        st_drv[0] = 1'b0;
        repeat (200) @(posedge clk); #2;
        exp_b = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
        check_bytes("after_rst", qb, exp_b);
        chk("after_rst_ferr", 32'(ferr - fb), 32'd0);

        // Two clocks per bit, all-zero word.
        @(negedge clk);
        dt_drv[1] = 32'h0; st_drv[1] = 1'b1;
        @(posedge clk); #2;
        st_drv[1] = 1'b0;
        n = 1; low = 0;
        while (!drd[1] && n < 200) begin
            if (!txo[1]) low++;
            @(posedge clk); #2;
            n++;
        end
        chk("cpb2_latency", 32'(n), 32'd81);
        chk("cpb2_low_cycles", 32'(low), 32'd72);

        // Random requests and data on both instances.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                st_drv[i] = ($urandom_range(0, 15) == 0);
                dt_drv[i] = $urandom;
            end
        end
        @(negedge clk);
        st_drv[0] = 1'b0; st_drv[1] = 1'b0;
        repeat (400) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Transmit side of the debug UART link. Serialises one 32-bit word as four 8N1 UART frames on TX.
- Signals completion to the debug transmit FSM, which drives tx_start/UART_data and waits on tx_dataready.
- Sits directly downstream of the debug unit's send state machine, between it and the board TX pin.
- Contains its own baud-rate counter. No dependency on the RX path.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- CNT_W, 16, width of the baud counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_start  in  1  request to send a word; level or pulse; sampled only in IDLE
- tx_data  in  32  word to send; captured on the accepting edge
- tx  out  1  serial line; idle high
- busy  out  1  high from the accepting edge until return to IDLE
- tx_dataready  out  1  one-cycle pulse once the last stop bit has completed

Behaviour:
- Reset (async, rst=1): state=IDLE, tx=1, busy=0, tx_dataready=0, all counters 0, shift register 0.
- Reset mid-frame: line returns high immediately; the partial word is discarded; no tx_dataready pulse.
- State machine: IDLE, START, DATA, STOP, DONE.
- IDLE:
  - tx=1, busy=0.
  - If tx_start=1 at a posedge: latch tx_data into word_reg, byte_idx=0, baud_cnt=0, go to START, busy=1.
  - tx goes low in the cycle after the accepting edge (latency 1).
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles.
  - Then load byte = word_reg[8*byte_idx+7 : 8*byte_idx], bit_idx=0, go to DATA.
- DATA:
  - tx=byte[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On completion: if byte_idx<3, byte_idx+1 and go to START with no idle gap. If byte_idx==3, go to DONE.
- DONE:
  - Lasts one cycle; tx=1, tx_dataready=1, busy=1.
  - Next cycle: IDLE, busy=0, tx_dataready=0.
- Byte order: least significant byte first (bits 7:0, 15:8, 23:16, 31:24).
- Timing:
  - Total line time from start-bit falling edge to end of last stop bit is exactly 40*CLKS_PER_BIT cycles.
  - tx_dataready asserts on the following cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; the bit advances when baud_cnt==CLKS_PER_BIT-1.
  - Wraps to 0 on every bit boundary. No drift accumulates across the 40 bits.
- tx_start handling:
  - Ignored in START/DATA/STOP/DONE. No queuing.
  - A request held high through DONE is accepted only on the first IDLE edge, so a held tx_start starts back-to-back words with a 1-cycle IDLE gap.
- tx_data changes while busy do not affect the word in flight.
- tx is driven from a register, so the line is glitch-free.

Test Plan:
- Reset / idle: assert rst mid-run, release, hold tx_start=0 for 100 cycles → tx=1, busy=0, tx_dataready=0 throughout.
- Single word (CLKS_PER_BIT=4): tx_start pulse with tx_data=0x12345678 → frames 0x78, 0x56, 0x34, 0x12 decoded LSB-first with valid start/stop bits; start bit begins 1 cycle after acceptance; tx_dataready high for exactly 1 cycle, 161 cycles after the accepting edge.
- Data stability: change tx_data to 0xFFFFFFFF one cycle after acceptance → line still carries 0x12345678.
- Ignored request: extra tx_start pulses during DATA and during DONE → exactly one word sent, one tx_dataready pulse.
- Back-to-back: tx_start held high, tx_data=0xA5A5A5A5 then 0x00000000 → two complete words with a 1-cycle idle-high gap between the last stop bit and the next start bit; two dataready pulses.
- Reset mid-frame: assert rst during byte 2, bit 3 → tx=1 the same cycle; no dataready pulse; next word after release is sent intact.
- Boundary: CLKS_PER_BIT=2, tx_data=0x00000000 → each bit exactly 2 cycles, 80 cycles of line time.
